// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and constants for the March C- BIST controller.
//   state_e     : controller FSM states (IDLE, RUN, FLUSH, DONE)
//   elem_e      : march element index E0..E5
//   elem_cfg_t  : per-element attributes (direction, read/write backgrounds,
//                 which operations the element contains)
//   elem_cfg()  : element -> attribute lookup
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        EL_0 = 3'd0,
        EL_1 = 3'd1,
        EL_2 = 3'd2,
        EL_3 = 3'd3,
        EL_4 = 3'd4,
        EL_5 = 3'd5
    } elem_e;

    typedef struct packed {
        logic down;    // address order N-1..0
        logic rd_val;  // expected background of the read
        logic wr_val;  // background written
        logic has_rd;
        logic has_wr;
    } elem_cfg_t;

    localparam elem_e ELEM_FIRST = EL_0;
    localparam elem_e ELEM_LAST  = EL_5;

    // March C-: (w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) (r0)
    function automatic elem_cfg_t elem_cfg(elem_e e);
        elem_cfg_t c;
        case (e)
            EL_0:    c = '{down: 1'b0, rd_val: 1'b0, wr_val: 1'b0, has_rd: 1'b0, has_wr: 1'b1};
            EL_1:    c = '{down: 1'b0, rd_val: 1'b0, wr_val: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
            EL_2:    c = '{down: 1'b0, rd_val: 1'b1, wr_val: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
            EL_3:    c = '{down: 1'b1, rd_val: 1'b0, wr_val: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
            EL_4:    c = '{down: 1'b1, rd_val: 1'b1, wr_val: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
            EL_5:    c = '{down: 1'b0, rd_val: 1'b0, wr_val: 1'b0, has_rd: 1'b1, has_wr: 1'b0};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: loadable up/down address counter for the march sequence.
//   CLK, RSTN : clock, synchronous active-low reset (counter -> 0)
//   load      : load load_val (has priority over step)
//   load_val  : start address of the next element
//   step      : advance one address in the direction given by down
//   down      : 1 = count N-1..0, 0 = count 0..N-1
//   addr      : current address
//   last      : current address is the final one for the direction
module mbist_addr_gen #(
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (step) begin
            addr_d = down ? (addr_q - ONE) : (addr_q + ONE);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // The FSM reloads on last, so the counter never wraps.
    assign last = down ? (addr_q == '0) : (addr_q == '1);
    assign addr = addr_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST controller for one single-port sync SRAM.
//   CLK, RSTN  : clock shared with the SRAM; synchronous active-low reset
//   start      : one-cycle run request, honoured in IDLE or DONE
//   busy/done  : run in progress / run finished (held until next start)
//   fail       : sticky miscompare flag for the current run
//   fail_cnt   : saturating count of miscompared reads
//   fail_addr, fail_elem, fail_mask : diagnostics of the first miscompare
//   CEN, WEN, A, D, OEN : SRAM control (active-low enables), address, data
//   Q          : SRAM read data, valid the cycle after the read edge
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_mask,
    output logic              CEN,
    output logic              WEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic              OEN,
    input  logic [DATA_W-1:0] Q
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    elem_e             elem_q, elem_d;
    elem_e             elem_nxt;
    logic              phase_q, phase_d;   // 0 = read slot, 1 = write slot
    elem_cfg_t         cfg;

    logic              ag_load;
    logic              ag_step;
    logic [ADDR_W-1:0] ag_load_val;
    logic [ADDR_W-1:0] addr;
    logic              ag_last;

    logic              run;
    logic              is_rd;
    logic              clr_status;

    logic              vld_p1_q, vld_p1_d;
    logic [DATA_W-1:0] exp_p1_q, exp_p1_d;
    logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;
    logic [2:0]        elem_p1_q, elem_p1_d;

    logic              fail_q, fail_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [DATA_W-1:0] fail_mask_q, fail_mask_d;
    logic [DATA_W-1:0] diff;

    mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .load     (ag_load),
        .load_val (ag_load_val),
        .step     (ag_step),
        .down     (cfg.down),
        .addr     (addr),
        .last     (ag_last)
    );

    assign cfg      = elem_cfg(elem_q);
    assign elem_nxt = elem_e'(elem_q + 3'd1);

    // ---------------- sequencer ----------------
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        phase_d     = phase_q;
        ag_load     = 1'b0;
        ag_load_val = '0;
        ag_step     = 1'b0;
        clr_status  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    elem_d     = ELEM_FIRST;
                    phase_d    = 1'b0;
                    ag_load    = 1'b1;
                    clr_status = 1'b1;
                end
            end
            ST_RUN: begin
                if (cfg.has_rd && cfg.has_wr && !phase_q) begin
                    // read slot of a read-write pair: write same address next
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (ag_last) begin
                        ag_load = 1'b1;
                        if (elem_q == ELEM_LAST) begin
                            state_d = ST_FLUSH;
                        end else begin
                            elem_d      = elem_nxt;
                            ag_load_val = elem_cfg(elem_nxt).down ? '1 : '0;
                        end
                    end else begin
                        ag_step = 1'b1;
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // SRAM interface is decoded from the current state so each op lands
    // on the very next edge without a gap between elements.
    always_comb begin
        run   = (state_q == ST_RUN);
        is_rd = run && cfg.has_rd && !phase_q;
        CEN   = !run;
        WEN   = !(run && !is_rd);
        A     = addr;
        D     = (run && !is_rd && cfg.wr_val) ? '1 : '0;
        OEN   = 1'b0;
        busy  = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        done  = (state_q == ST_DONE);
    end

    // ---------------- compare pipeline ----------------
    always_comb begin
        vld_p1_d    = is_rd;
        exp_p1_d    = {DATA_W{cfg.rd_val}};
        addr_p1_d   = addr;
        elem_p1_d   = elem_q;
        diff        = Q ^ exp_p1_q;
        fail_d      = fail_q;
        fail_cnt_d  = fail_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_mask_d = fail_mask_q;
        if (clr_status) begin
            fail_d      = 1'b0;
            fail_cnt_d  = '0;
            fail_addr_d = '0;
            fail_elem_d = '0;
            fail_mask_d = '0;
        end else if (vld_p1_q && (diff != '0)) begin
            fail_d = 1'b1;
            if (fail_cnt_q != '1) begin
                fail_cnt_d = fail_cnt_q + CNT_ONE;
            end
            if (!fail_q) begin
                fail_addr_d = addr_p1_q;
                fail_elem_d = elem_p1_q;
                fail_mask_d = diff;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            elem_q      <= ELEM_FIRST;
            phase_q     <= 1'b0;
            vld_p1_q    <= 1'b0;
            exp_p1_q    <= '0;
            addr_p1_q   <= '0;
            elem_p1_q   <= '0;
            fail_q      <= 1'b0;
            fail_cnt_q  <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            vld_p1_q    <= vld_p1_d;
            exp_p1_q    <= exp_p1_d;
            addr_p1_q   <= addr_p1_d;
            elem_p1_q   <= elem_p1_d;
            fail_q      <= fail_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign fail      = fail_q;
    assign fail_cnt  = fail_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: bench for mbist_march_ctrl with a small SRAM model
// carrying per-address stuck-at masks, a March C- reference model that
// produces the expected op stream and diagnostics, a table of fault cases,
// randomized fault runs and hand-written abort / restart sequences.
module tb_mbist_march_ctrl;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int CW   = 3;
    localparam int N    = 1 << AW;
    localparam int NOPS = 10 * N;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail, CEN, WEN, OEN;
    logic [CW-1:0] fail_cnt;
    logic [AW-1:0] fail_addr, A;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_mask, D;
    logic [DW-1:0] Q = '0;

    always #5 CLK = ~CLK;

    mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .CLK(CLK), .RSTN(RSTN), .start(start), .busy(busy), .done(done),
        .fail(fail), .fail_cnt(fail_cnt), .fail_addr(fail_addr),
        .fail_elem(fail_elem), .fail_mask(fail_mask), .CEN(CEN), .WEN(WEN),
        .A(A), .D(D), .OEN(OEN), .Q(Q)
    );

    // SRAM with stuck-at faults applied on write; Q changes only on reads
    logic [DW-1:0] mem [N];
    logic [DW-1:0] sa0 [N];
    logic [DW-1:0] sa1 [N];

    always @(posedge CLK) begin
        if (!CEN) begin
            if (!WEN) mem[A] <= (D & ~sa0[A]) | sa1[A];
            else      Q <= mem[A];
        end
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct packed {
        logic          fail;
        logic [CW-1:0] cnt;
        logic [AW-1:0] addr;
        logic [2:0]    elem;
        logic [DW-1:0] mask;
    } res_t;

    typedef struct {
        int   nf;
        int   fa [3];
        int   fb [3];
        bit   fv [3];
        res_t exp;
    } vec_t;

    op_t           exp_ops [$];
    logic          log_we [NOPS];
    logic [AW-1:0] log_a [NOPS];
    vec_t          vecs [6];
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    task automatic add_fault(input int a, input int b, input bit v);
        if (v) sa1[a][b] = 1'b1;
        else   sa0[a][b] = 1'b1;
    endtask

    // March C- walked element by element: E0 w0, then pairs r/w with
    // backgrounds alternating, E3/E4 descending, E5 read-only.
    task automatic build_model(output res_t r);
        logic [DW-1:0] m [N];
        op_t op;
        r = '0;
        exp_ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                int a;
                logic [DW-1:0] bg, wv;
                a  = (e == 3 || e == 4) ? N - 1 - i : i;
                bg = (e > 0 && e % 2 == 0) ? '1 : '0;
                wv = (e % 2 == 1) ? '1 : '0;
                if (e > 0) begin
                    op.we = 1'b0; op.addr = AW'(a); op.data = '0;
                    exp_ops.push_back(op);
                    if (m[a] != bg) begin
                        if (!r.fail) begin
                            r.addr = AW'(a);
                            r.elem = 3'(e);
                            r.mask = m[a] ^ bg;
                        end
                        r.fail = 1'b1;
                        if (r.cnt != '1) r.cnt = r.cnt + 1'b1;
                    end
                end
                if (e < 5) begin
                    op.we = 1'b1; op.addr = AW'(a); op.data = wv;
                    exp_ops.push_back(op);
                    m[a] = (wv & ~sa0[a]) | sa1[a];
                end
            end
        end
    endtask

    // Pulses start, then follows the run one sample per cycle (#1 after the
    // edge). edges = edges from the start edge to done (-1 if never).
    task automatic run_march(input int poke_at, output int edges, output int ops, output int bad);
        edges = -1; ops = 0; bad = 0;
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        for (int k = 0; k <= NOPS + 20; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                #1 start = (k == poke_at);
            end
            if (k == 0 && (done || fail || fail_cnt != '0)) bad++;
            if (done) begin
                if (busy || !CEN || !WEN) bad++;
                edges = k;
                break;
            end
            if (!busy) bad++;
            if (!CEN) begin
                if (ops < NOPS) begin
                    log_we[ops] = !WEN;
                    log_a[ops]  = A;
                    if (exp_ops[ops].we != !WEN || exp_ops[ops].addr != A ||
                        (exp_ops[ops].we && exp_ops[ops].data != D)) bad++;
                end else begin
                    bad++;
                end
                ops++;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int edges, input int ops, input int bad);
        check({tag, "_latency"}, 64'(edges), 64'(NOPS + 1));
        check({tag, "_opcount"}, 64'(ops), 64'(NOPS));
        check({tag, "_busseq"}, 64'(bad), 64'd0);
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, "_fail"}, 64'(fail), 64'(e.fail));
        check({tag, "_cnt"}, 64'(fail_cnt), 64'(e.cnt));
        check({tag, "_addr"}, 64'(fail_addr), 64'(e.addr));
        check({tag, "_elem"}, 64'(fail_elem), 64'(e.elem));
        check({tag, "_mask"}, 64'(fail_mask), 64'(e.mask));
    endtask

    task automatic tv(input int i, input int nf,
                      input int a0, input int b0, input bit v0,
                      input int a1, input int b1, input bit v1,
                      input int a2, input int b2, input bit v2,
                      input logic f, input int c, input int ad, input int el,
                      input logic [DW-1:0] mk);
        vecs[i].nf = nf;
        vecs[i].fa[0] = a0; vecs[i].fb[0] = b0; vecs[i].fv[0] = v0;
        vecs[i].fa[1] = a1; vecs[i].fb[1] = b1; vecs[i].fv[1] = v1;
        vecs[i].fa[2] = a2; vecs[i].fb[2] = b2; vecs[i].fv[2] = v2;
        vecs[i].exp = '{fail: f, cnt: CW'(c), addr: AW'(ad), elem: 3'(el), mask: mk};
    endtask

    initial begin
        int   edges, ops, bad, cnt0;
        res_t mr;

        // fault-free; sa0 b17 @4; sa1 b0 @N-1; two faults; saturation; two sa0
        tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 32'h0);
        tv(1, 1, 4, 17, 0, 0, 0, 0, 0, 0, 0, 1'b1, 2, 4, 2, 32'h0002_0000);
        tv(2, 1, N-1, 0, 1, 0, 0, 0, 0, 0, 0, 1'b1, 3, N-1, 1, 32'h0000_0001);
        tv(3, 2, 0, 31, 1, 16, 5, 0, 0, 0, 0, 1'b1, 5, 0, 1, 32'h8000_0000);
        tv(4, 3, 1, 3, 1, 2, 3, 1, 3, 3, 1, 1'b1, 7, 1, 1, 32'h0000_0008);
        tv(5, 2, 0, 0, 0, N-1, 1, 0, 0, 0, 0, 1'b1, 4, 0, 2, 32'h0000_0001);

        clear_faults();
        RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_sram", 64'({CEN, WEN, A, D, OEN}), 64'({1'b1, 1'b1, AW'(0), DW'(0), 1'b0}));
        check("rst_status", 64'({busy, done, fail, fail_cnt, fail_addr, fail_elem}), 64'd0);
        check("rst_mask", 64'(fail_mask), 64'd0);
        RSTN = 1'b1;

        for (int i = 0; i < 6; i++) begin
            clear_faults();
            for (int j = 0; j < vecs[i].nf; j++) add_fault(vecs[i].fa[j], vecs[i].fb[j], vecs[i].fv[j]);
            build_model(mr);
            run_march(-1, edges, ops, bad);
            check_run($sformatf("vec%0d", i), edges, ops, bad);
            check_res($sformatf("vec%0d", i), vecs[i].exp);
            if (i == 0) begin
                check("order_e0_last", 64'({log_we[N-1], log_a[N-1]}), 64'({1'b1, AW'(N-1)}));
                check("order_e1_first", 64'({log_we[N], log_a[N]}), 64'({1'b0, AW'(0)}));
                check("order_e3_first", 64'({log_we[5*N], log_a[5*N]}), 64'({1'b0, AW'(N-1)}));
            end
        end

        for (int r = 0; r < 4; r++) begin
            int nf;
            clear_faults();
            nf = $urandom_range(1, 3);
            for (int j = 0; j < nf; j++)
                add_fault($urandom_range(0, N-1), $urandom_range(0, DW-1), 1'($urandom_range(0, 1)));
            build_model(mr);
            run_march(-1, edges, ops, bad);
            check_run($sformatf("rnd%0d", r), edges, ops, bad);
            check_res($sformatf("rnd%0d", r), mr);
        end

        // start pulsed mid-run must not disturb anything
        clear_faults();
        build_model(mr);
        run_march(500, edges, ops, bad);
        check_run("startrun", edges, ops, bad);
        check_res("startrun", mr);

        // failing run left in DONE, then restart fault-free from DONE
        clear_faults();
        add_fault(4, 17, 0);
        build_model(mr);
        run_march(-1, edges, ops, bad);
        check("pre_restart_fail", 64'({done, fail}), 64'b11);
        clear_faults();
        build_model(mr);
        run_march(-1, edges, ops, bad);
        check_run("restart", edges, ops, bad);
        check_res("restart", mr);

        // reset mid-run at cycle 1000 (inside E2, after the fault fired)
        clear_faults();
        add_fault(4, 17, 0);
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        repeat (1000) @(posedge CLK);
        #1;
        check("abort_prefail", 64'({busy, fail}), 64'b11);
        RSTN = 1'b0;
        @(posedge CLK);
        #1 RSTN = 1'b1;
        check("abort_state", 64'({CEN, busy, done, fail, fail_cnt}), 64'({1'b1, 1'b0, 1'b0, 1'b0, CW'(0)}));
        cnt0 = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (!CEN || busy) cnt0++;
        end
        check("abort_quiet", 64'(cnt0), 64'd0);
        clear_faults();
        build_model(mr);
        run_march(-1, edges, ops, bad);
        check_run("postabort", edges, ops, bad);
        check_res("postabort", mr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
